zint_gen: RTL

- Raster interrupt-start generator; sits directly upstream of the Z80 interrupt controller and drives its int_start_frm / int_start_lin inputs.
- Tracks the beam position from video-timing strobes and pixel clock-enables, compares it against programmable positions, and emits single-clk start pulses.
- Position registers are CPU-written into shadows and become active only at frame start.

---
 rtl/zint_gen.sv | 122 ++++++++++++
 1 files changed

// File: rtl/zint_gen.sv
`default_nettype none
// ============================================================================
// Module   : zint_gen
// Purpose  : Raster interrupt-start pulse generator for the Z80 INT controller.
//            Optional line divider built when ZINT_GEN_LINEDIV_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module zint_gen #(
  parameter int HW   = 9,
  parameter int VW   = 9,
  parameter int VMAX = 319
) (
  input  logic          clk,
  input  logic          res_n,
  input  logic          pix_cen,
  input  logic          line_start,
  input  logic          frame_start,
  input  logic          wr_en,
  input  logic [1:0]    wr_addr,
  input  logic [7:0]    wr_data,
  output logic          int_start_frm,
  output logic          int_start_lin,
  output logic [VW-1:0] vcnt
);

  localparam logic [HW-1:0] H_SAT  = {HW{1'b1}};
  localparam logic [VW-1:0] V_LAST = VW'(VMAX);
  localparam logic [VW-1:0] V_SAT  = VW'(VMAX + 1);

  logic [HW-1:0] hcnt;
  logic [7:0]    hint_sh, hint_act, hint_nx;
  logic [8:0]    vint_sh, vint_act, vint_nx;
  logic          hmatch_c, lmatch_c, fmatch_c;
  logic          lmatch, fmatch;
  logic          lin_rise, lin_fire;

  // Next shadow value, so a write landing on the frame_start clk is what gets activated.
  always_comb begin
    hint_nx = hint_sh;
    vint_nx = vint_sh;
    if (wr_en) begin
      case (wr_addr)
        2'd0:    hint_nx      = wr_data;
        2'd1:    vint_nx[7:0] = wr_data;
        2'd2:    vint_nx[8]   = wr_data[0];
        default: ;
      endcase
    end
  end

  // Lines past VMAX (saturated vcnt) never qualify, for either pulse.
  assign hmatch_c = (hcnt[8:1] == hint_act);
  assign lmatch_c = hmatch_c && (vcnt <= V_LAST);
  assign fmatch_c = lmatch_c && (vcnt == VW'(vint_act));
  assign lin_rise = lmatch_c && !lmatch;

`ifdef ZINT_GEN_LINEDIV_EN
  logic [7:0] linediv_sh, linediv_act, linediv_nx, divctr;

  assign linediv_nx = (wr_en && (wr_addr == 2'd3)) ? wr_data : linediv_sh;
  assign lin_fire   = lin_rise && (divctr == 8'd0);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      linediv_sh  <= 8'd0;
      linediv_act <= 8'd0;
      divctr      <= 8'd0;
    end else begin
      linediv_sh <= linediv_nx;
      if (frame_start) begin
        linediv_act <= linediv_nx;
        divctr      <= 8'd0;
      end else if (lin_rise) begin
        divctr <= (divctr == linediv_act) ? 8'd0 : divctr + 8'd1;
      end
    end
  end
`else
  assign lin_fire = lin_rise;
`endif

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      hcnt          <= '0;
      vcnt          <= '0;
      hint_sh       <= 8'd0;
      hint_act      <= 8'd0;
      vint_sh       <= 9'd0;
      vint_act      <= 9'd0;
      lmatch        <= 1'b0;
      fmatch        <= 1'b0;
      int_start_frm <= 1'b0;
      int_start_lin <= 1'b0;
    end else begin
      if (frame_start || line_start) begin
        hcnt <= '0;
      end else if (pix_cen && (hcnt != H_SAT)) begin
        hcnt <= hcnt + HW'(1);
      end

      if (frame_start) begin
        vcnt <= '0;
      end else if (line_start && (vcnt < V_SAT)) begin
        vcnt <= vcnt + VW'(1);
      end

      hint_sh <= hint_nx;
      vint_sh <= vint_nx;
      if (frame_start) begin
        hint_act <= hint_nx;
        vint_act <= vint_nx;
      end

      lmatch        <= lmatch_c;
      fmatch        <= fmatch_c;
      int_start_frm <= fmatch_c && !fmatch;
      int_start_lin <= lin_fire;
    end
  end

endmodule
`default_nettype wire
